// File: rtl/aes_inv_key_sched_pkg.sv
// Shared AES definitions for the inverse key scheduler.
//   - state_e     : scheduler FSM states (IDLE, FWD, REV)
//   - NUM_ROUNDS  : AES-128 round count (10)
//   - SBOX        : forward AES S-box table
//   - sbox()      : single-byte forward S-box lookup
//   - rot_word()  : cyclic left rotation of a word by one byte
//   - rcon_byte() : round constant (top byte of Rcon word) for rounds 1..10
package aes_inv_key_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2
    } state_e;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rounds outside 1..10 yield zero; the datapath never uses them.
    function automatic logic [7:0] rcon_byte(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_inv_key_sched_sub_word.sv
// aes_sub_word: applies the forward AES S-box to each byte of a 32-bit word.
//   word_i : input word
//   word_o : SubWord(word_i)
module aes_sub_word
    import aes_inv_key_sched_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                  sbox(word_i[15:8]),  sbox(word_i[7:0])};
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: AES-128 key scheduler that emits round keys in
// decryption order (round 10 first, round 0 last).
//
// After start, the cipher key is expanded forward one round per cycle into a
// single 128-bit register until it holds the round-10 key; the keys are then
// streamed out while the register is stepped backwards, one inverse round per
// accepted key. No table of round keys is kept.
//
// Ports:
//   clk       : clock, all state rises on clk
//   rst_n     : asynchronous active-low reset
//   start     : schedule key_in (sampled only in IDLE)
//   clear     : synchronous abort to IDLE, highest priority
//   key_in    : 128-bit cipher key, w0 = [127:96]
//   round_key : current round key
//   round_idx : round number of round_key (10 down to 0)
//   out_valid : round_key/round_idx valid
//   out_ready : consumer ready
//   out_last  : out_valid at round_idx 0
//   busy      : not IDLE
//
// Handshake: a key is transferred on a rising clk edge where
// out_valid & out_ready are both high. While out_valid is high and out_ready
// is low, round_key, round_idx, out_valid and out_last hold their values.
module aes_inv_key_sched
    import aes_inv_key_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clear,
    input  logic [127:0] key_in,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    state_e        state_q, state_d;
    logic [127:0]  key_q, key_d;
    logic [3:0]    ctr_q, ctr_d;

    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   inv_w3;
    logic [31:0]   sw_in, sw_out, t_word;
    logic [3:0]    rcon_idx;
    logic [127:0]  fwd_key, inv_key;
    logic          hs;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Inverse step recovers the previous w3 first; SubWord then works on it.
    assign inv_w3 = w3 ^ w2;

    // One S-box word path shared by both directions. In FWD the counter holds
    // the round already reached, so the step builds round ctr+1; in REV it
    // holds the round currently presented, which is undone with Rcon[ctr].
    always_comb begin
        sw_in    = rot_word(w3);
        rcon_idx = ctr_q + 4'd1;
        if (state_q == ST_REV) begin
            sw_in    = rot_word(inv_w3);
            rcon_idx = ctr_q;
        end
    end

    aes_sub_word u_sub_word (
        .word_i (sw_in),
        .word_o (sw_out)
    );

    assign t_word = sw_out ^ {rcon_byte(rcon_idx), 24'h000000};

    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0      = w0 ^ t_word;
        f1      = w1 ^ f0;
        f2      = w2 ^ f1;
        f3      = w3 ^ f2;
        fwd_key = {f0, f1, f2, f3};
    end

    assign inv_key = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, inv_w3};

    assign out_valid = (state_q == ST_REV);
    assign out_last  = out_valid && (ctr_q == 4'd0);
    assign busy      = (state_q != ST_IDLE);
    assign round_key = key_q;
    assign round_idx = ctr_q;
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ctr_d   = ctr_q;
        if (clear) begin
            state_d = ST_IDLE;
            ctr_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        key_d   = key_in;
                        ctr_d   = 4'd0;
                        state_d = ST_FWD;
                    end
                end
                ST_FWD: begin
                    // The cycle after the 10th step only hands over to REV.
                    if (ctr_q == NUM_ROUNDS) begin
                        state_d = ST_REV;
                    end else begin
                        key_d = fwd_key;
                        ctr_d = ctr_q + 4'd1;
                    end
                end
                ST_REV: begin
                    if (hs) begin
                        if (ctr_q == 4'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            key_d = inv_key;
                            ctr_d = ctr_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ctr_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= 128'd0;
            ctr_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
module tb_aes_inv_key_sched;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         clear;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];
  logic [127:0] exp_q [$];
  int           cur_idx;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  aes_inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .key_in    (key_in),
    .round_key (round_key),
    .round_idx (round_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: GF(2^8) arithmetic and FIPS-197 word expansion
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back(exp_rk[r]);
  endtask

  // driver tasks
  // Start edge plus wait for first out_valid; expects it 11 edges later.
  task automatic launch(input logic [127:0] key, input bit poke);
    int n;
    model_expand(key);
    key_in = key;
    start = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'd1);
    n = 0;
    do begin
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      n++;
      if (out_valid !== 1'b1) check("valid_low_fwd", 128'(out_valid), 128'd0);
    end while (out_valid !== 1'b1 && n < 40);
    start = 1'b0;
    check("first_valid_latency", 128'(n), 128'd11);
    cur_idx = 10;
  endtask

  // Streams keys until the queue empties or round stop_idx is presented.
  task automatic stream(input bit rand_ready, input bit poke, input int stop_idx);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      check("out_valid", 128'(out_valid), 128'd1);
      check("round_idx", 128'(round_idx), 128'(cur_idx));
      check("round_key", round_key, exp_q[0]);
      check("out_last", 128'(out_last), 128'(cur_idx == 0));
      check("busy_rev", 128'(busy), 128'd1);
      got_rk[cur_idx] = round_key;
      if (cur_idx == stop_idx) return;
      out_ready = (rand_ready && cyc < 150) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (out_ready) begin
        void'(exp_q.pop_front());
        cur_idx--;
      end
      cyc++;
    end
    check("stream_complete", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic run_schedule(input logic [127:0] key, input bit rand_ready, input bit poke);
    launch(key, poke);
    stream(rand_ready, poke, -1);
    out_ready = 1'b0;
    check("valid_after_last", 128'(out_valid), 128'd0);
    check("busy_after_last", 128'(busy), 128'd0);
    check("last_after_last", 128'(out_last), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    key_in = '0;
    out_ready = 1'b0;
    build_sbox();
    #12;
    check("reset_key", round_key, 128'd0);
    check("reset_idx", 128'(round_idx), 128'd0);
    check("reset_valid", 128'(out_valid), 128'd0);
    check("reset_last", 128'(out_last), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 key, ready held high: no gaps, known round keys
    run_schedule(KEY_A, 1'b0, 1'b0);
    check("a_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("a_rk9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    check("a_rk0", got_rk[0], KEY_A);

    // same key with random back-pressure, then with start pokes
    run_schedule(KEY_A, 1'b1, 1'b0);
    run_schedule(KEY_A, 1'b1, 1'b1);
    check("a_poke_rk0", got_rk[0], KEY_A);

    // clear at round 5 together with start
    launch(KEY_B, 1'b0);
    stream(1'b0, 1'b0, 5);
    clear = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    key_in = KEY_A;
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    check("clear_valid", 128'(out_valid), 128'd0);
    check("clear_busy", 128'(busy), 128'd0);
    check("clear_last", 128'(out_last), 128'd0);
    run_schedule(KEY_A, 1'b0, 1'b0);

    // async reset during FWD
    key_in = KEY_B;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_key", round_key, 128'd0);
    check("rst_mid_idx", 128'(round_idx), 128'd0);
    check("rst_mid_valid", 128'(out_valid), 128'd0);
    check("rst_mid_last", 128'(out_last), 128'd0);
    check("rst_mid_busy", 128'(busy), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle_valid", 128'(out_valid), 128'd0);
      check("post_rst_idle_busy", 128'(busy), 128'd0);
    end
    run_schedule(KEY_B, 1'b0, 1'b0);
    check("b_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("b_rk0", got_rk[0], KEY_B);

    // random keys
    for (int k = 0; k < 4; k++)
      run_schedule({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 SHALL have parameters: none; round count fixed at 10 (AES-128).
REQ-002 SHALL have port clk, input, 1, the single clock; all state rises on clk.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to schedule key_in; sampled only in IDLE.
REQ-005 SHALL have port clear, input, 1, synchronous abort to IDLE.
REQ-006 SHALL have port key_in, input, 128, AES-128 cipher key; word w0 = [127:96].
REQ-007 SHALL have port round_key, output, 128, current round key, decryption order.
REQ-008 SHALL have port round_idx, output, 4, round number of round_key (10 down to 0).
REQ-009 SHALL have port out_valid, output, 1, round_key/round_idx valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts when out_valid & out_ready.
REQ-011 SHALL have port out_last, output, 1, high with out_valid when round_idx = 0.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, FWD, REV.
REQ-014 SHALL, in IDLE with start=1 and clear=0, load key_in into the key register, set round counter to 0, and enter FWD.
REQ-015 SHALL, in FWD, apply one forward expansion step per cycle: w0'=w0^SubWord(RotWord(w3))^Rcon[r]; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'; r increments 1..10.
REQ-016 SHALL, after the 10th FWD step, enter REV with out_valid=1, round_idx=10, round_key = round-10 key; first out_valid is 11 cycles after the start edge.
REQ-017 SHALL, in REV, on each handshake with round_idx=r>0, apply one inverse step: w3'=w3^w2; w2'=w2^w1; w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^Rcon[r]; round_idx becomes r-1 next cycle.
REQ-018 SHALL hold round_key, round_idx, out_valid, out_last stable while out_valid=1 and out_ready=0.
REQ-019 SHALL emit exactly 11 keys per start, indices 10,9,...,0, with no gap cycles when out_ready is held high.
REQ-020 SHALL, on handshake at round_idx=0 (out_last=1), return to IDLE and deassert out_valid the next cycle.
REQ-021 SHALL ignore start when not in IDLE.
REQ-022 SHALL, on clear=1 in any state, enter IDLE next cycle with out_valid=0; clear wins over a simultaneous start or handshake.
REQ-023 SHALL keep out_valid=0 in IDLE and FWD.
REQ-024 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the top byte of the word, other bytes zero.

Reset
REQ-025 SHALL, with rst_n=0, asynchronously force state=IDLE, round_key=0, round_idx=0, out_valid=0, out_last=0, busy=0, counter=0.
REQ-026 SHALL, on reset mid-schedule, discard all progress; no output until a new start after rst_n=1.

Structure
REQ-027 SHALL place the Rcon table, the state enumeration and the round-count constant (10) in the shared AES package.
REQ-028 SHALL instantiate one sub-module, aes_sub_word (four forward S-box lookups on a 32-bit word), shared by the FWD and REV datapaths via the single word path selected by state.
REQ-029 SHALL use a single 128-bit key register for both directions; no storage of all 11 round keys.

Verification
REQ-030 SHALL test: key_in=2b7e151628aed2a6abf7158809cf4f3c, start, out_ready=1 -> cycle 11 round_idx=10 round_key=d014f9a8c9ee2589e13f0cc8b6630ca6; next cycle round_idx=9 key=ac7766f319fadc2128d12941575c006e; round_idx=0 key equals key_in with out_last=1.
REQ-031 SHALL test: same key, out_ready toggled randomly -> 11 keys in order, each held stable during stall, values match FIPS-197 A.1 reversed.
REQ-032 SHALL test: start pulsed during FWD and REV -> ignored; sequence unaffected.
REQ-033 SHALL test: clear at round_idx=5 with start=1 same cycle -> IDLE, out_valid=0 next cycle; start sampled only the cycle after.
REQ-034 SHALL test: rst_n low during FWD cycle 4 -> all outputs 0 immediately; fresh start after release yields full correct sequence.
REQ-035 SHALL test: key_in=000102030405060708090a0b0c0d0e0f -> round_idx=10 key=13111d7fe3944a17f307a78b4d2b30c5, round 0 = key_in.
